// File: rtl/paddle_driver_pkg.sv
// paddle_driver_pkg: shared state/direction codes and field geometry for the paddle step driver.
package paddle_driver_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} stateT;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dirT;
  typedef enum logic [1:0] {REQ_NONE = 2'd0, REQ_UP = 2'd1, REQ_DOWN = 2'd2} reqT;
  localparam int FIELD_ROWS = 32;
  localparam int PADDLE_TOP_BIT = 31;
  localparam int PADDLE_BOTTOM_BIT = 0;
  localparam int TIMER_BITS = 20;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes an active-low raw key and accepts a level only after it has stayed stable.
module key_debounce
  import paddle_driver_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic db
);
  logic [SYNC_STAGES-1:0] syncChain;
  logic [TIMER_BITS-1:0] count;
  logic sync;
  assign sync = syncChain[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      syncChain <= '0;
      count <= '0;
      db <= 1'b0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], ~key};
      if (sync == db) count <= '0;
      else if (count == TIMER_BITS'(DEBOUNCE_CYCLES)) begin
        db <= sync;
        count <= '0;
      end else count <= count + 1'b1;
    end
endmodule

// File: rtl/paddle_driver.sv
// paddle_driver: turns two raw buttons into edge-guarded one-cycle paddle step pulses with auto-repeat.
module paddle_driver
  import paddle_driver_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_PERIOD = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic keyUp,
  input  logic keyDown,
  input  logic [FIELD_ROWS-1:0] verticalPosition,
  output logic moveUp,
  output logic moveDown
);
  logic dbUp, dbDown, pulse, match, nextUp, nextDown, unusedRows;
  stateT state, nextState;
  dirT dir, nextDir;
  reqT req;
  logic [TIMER_BITS-1:0] timer, nextTimer;
  assign unusedRows = ^verticalPosition[PADDLE_TOP_BIT-1:PADDLE_BOTTOM_BIT+1];
  key_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) upKey (
    .clk(clk), .reset(reset), .key(keyUp), .db(dbUp)
  );
  key_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) downKey (
    .clk(clk), .reset(reset), .key(keyDown), .db(dbDown)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      dir <= UP;
      timer <= '0;
      moveUp <= 1'b0;
      moveDown <= 1'b0;
    end else begin
      state <= nextState;
      dir <= nextDir;
      timer <= nextTimer;
      moveUp <= nextUp;
      moveDown <= nextDown;
    end
  // A request mismatch wins over timer expiry, so release on the expiry edge drops the pulse.
  always_comb begin
    req = (dbUp & ~dbDown) ? REQ_UP : (dbDown & ~dbUp) ? REQ_DOWN : REQ_NONE;
    match = (req == REQ_UP && dir == UP) || (req == REQ_DOWN && dir == DOWN);
    nextState = state;
    nextDir = dir;
    nextTimer = timer;
    if (state == IDLE) begin
      if (req != REQ_NONE) begin
        nextDir = (req == REQ_UP) ? UP : DOWN;
        nextTimer = TIMER_BITS'(REPEAT_DELAY);
        nextState = DELAY;
      end
    end else if (!match) nextState = IDLE;
    else if (timer == TIMER_BITS'(1)) begin
      nextTimer = TIMER_BITS'(REPEAT_PERIOD);
      nextState = REPEAT;
    end else nextTimer = timer - 1'b1;
  end
  // Masked pulses still advance the FSM; only the output is suppressed at the field edge.
  always_comb begin
    pulse = (state == IDLE) ? (req != REQ_NONE) : (match && timer == TIMER_BITS'(1));
    nextUp = pulse && nextDir == UP && !verticalPosition[PADDLE_TOP_BIT];
    nextDown = pulse && nextDir == DOWN && !verticalPosition[PADDLE_BOTTOM_BIT];
  end
endmodule

// File: tb/tb_paddle_driver.sv
// tb_paddle_driver: directed scenarios plus randomized key/position traffic against a rule-level reference model.
module tb_paddle_driver;
  localparam int S = 2, D = 4, RD = 10, RP = 3;
  logic clk = 1'b0, reset = 1'b0, keyUp = 1'b1, keyDown = 1'b1;
  logic [31:0] verticalPosition = 32'h000FF000;
  logic moveUp, moveDown;
  paddle_driver #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .keyUp(keyUp), .keyDown(keyDown),
    .verticalPosition(verticalPosition), .moveUp(moveUp), .moveDown(moveDown)
  );
  always #5 clk = ~clk;
  int testsRun = 0, failCount = 0, edgeNo = 0, base = 1, active = 0, nextPulse = 0, p = 0;
  bit hist[2][8192];
  bit dbm[2];
  bit expUp, expDown;
  int upQ[$], downQ[$];

  // Key level as seen by the debouncer: raw sample from S edges earlier, zero until it has crossed the synchronizer since reset.
  function automatic bit seenV(int k, int e);
    return (e - S >= base) ? hist[k][e-S] : 1'b0;
  endfunction

  task automatic check(string tag, logic got, logic want);
    testsRun++;
    assert (got === want) else begin
      failCount++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, edgeNo, got, want);
    end
  endtask

  task automatic checkInt(string tag, int got, int want);
    testsRun++;
    assert (got == want) else begin
      failCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step();
    int rq, pd;
    bit flip;
    @(posedge clk);
    edgeNo++;
    hist[0][edgeNo] = ~keyUp;
    hist[1][edgeNo] = ~keyDown;
    rq = (dbm[0] && !dbm[1]) ? 1 : (dbm[1] && !dbm[0]) ? 2 : 0;
    pd = 0;
    if (active == 0) begin
      if (rq != 0) begin
        pd = rq;
        active = rq;
        nextPulse = edgeNo + RD;
      end
    end else if (rq != active) active = 0;
    else if (edgeNo == nextPulse) begin
      pd = active;
      nextPulse = edgeNo + RP;
    end
    expUp = (pd == 1) && !verticalPosition[31];
    expDown = (pd == 2) && !verticalPosition[0];
    // A level is accepted once D+1 consecutive samples disagree with the current one.
    for (int k = 0; k < 2; k++) begin
      flip = 1'b1;
      for (int j = 0; j <= D; j++) if (seenV(k, edgeNo - j) == dbm[k]) flip = 1'b0;
      if (flip) dbm[k] = ~dbm[k];
    end
    #1;
    check("moveUp", moveUp, expUp);
    check("moveDown", moveDown, expDown);
    if (moveUp) upQ.push_back(edgeNo);
    if (moveDown) downQ.push_back(edgeNo);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic clearQ();
    upQ.delete();
    downQ.delete();
  endtask

  task automatic doReset(int n);
    reset = 1'b0;
    #1;
    check("rstUp", moveUp, 1'b0);
    check("rstDown", moveDown, 1'b0);
    repeat (n) begin
      @(posedge clk);
      edgeNo++;
      #1;
      check("rstHoldUp", moveUp, 1'b0);
      check("rstHoldDown", moveDown, 1'b0);
    end
    reset = 1'b1;
    dbm[0] = 1'b0;
    dbm[1] = 1'b0;
    active = 0;
    base = edgeNo + 1;
  endtask

  initial begin
    doReset(3);
    // single tap
    run(3);
    clearQ();
    keyUp = 1'b0;
    p = edgeNo + 1;
    run(8);
    keyUp = 1'b1;
    run(20);
    checkInt("tapCount", upQ.size(), 1);
    checkInt("tapLatency", (upQ.size() > 0) ? upQ[0] - p : -1, 7);
    checkInt("tapDown", downQ.size(), 0);
    // hold repeat
    clearQ();
    keyDown = 1'b0;
    p = edgeNo + 1;
    run(40);
    keyDown = 1'b1;
    run(30);
    checkInt("holdCount", downQ.size(), 11);
    if (downQ.size() >= 4) begin
      checkInt("holdFirst", downQ[0] - p, 7);
      checkInt("holdDelay", downQ[1] - downQ[0], RD);
      checkInt("holdPeriod1", downQ[2] - downQ[1], RP);
      checkInt("holdPeriod2", downQ[3] - downQ[2], RP);
    end
    // bounce
    clearQ();
    repeat (5) begin
      keyUp = 1'b0;
      run(2);
      keyUp = 1'b1;
      run(2);
    end
    run(20);
    checkInt("bounceCount", upQ.size() + downQ.size(), 0);
    // edge guard at the top row, then release the guard mid-hold
    clearQ();
    verticalPosition = 32'hFF000000;
    keyUp = 1'b0;
    p = edgeNo + 1;
    run(30);
    checkInt("guardCount", upQ.size(), 0);
    verticalPosition = 32'h7F800000;
    run(3);
    checkInt("unguardCount", upQ.size(), 1);
    checkInt("unguardEdge", (upQ.size() > 0) ? upQ[0] - p : -1, 32);
    keyUp = 1'b1;
    run(20);
    verticalPosition = 32'h000FF000;
    // both keys, then release up
    clearQ();
    keyUp = 1'b0;
    keyDown = 1'b0;
    run(20);
    checkInt("bothCount", upQ.size() + downQ.size(), 0);
    keyUp = 1'b1;
    p = edgeNo + 1;
    run(12);
    checkInt("swapLatency", (downQ.size() > 0) ? downQ[0] - p : -1, 7);
    keyDown = 1'b1;
    run(20);
    // up held, then down added
    keyUp = 1'b0;
    run(12);
    clearQ();
    keyDown = 1'b0;
    run(20);
    checkInt("addDownCount", downQ.size(), 0);
    keyUp = 1'b1;
    keyDown = 1'b1;
    run(20);
    // reset while repeating
    keyUp = 1'b0;
    run(25);
    doReset(2);
    clearQ();
    p = edgeNo + 1;
    run(10);
    checkInt("postResetLatency", (upQ.size() > 0) ? upQ[0] - p : -1, 7);
    keyUp = 1'b1;
    run(20);
    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      keyUp = 1'($urandom_range(0, 1));
      keyDown = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: verticalPosition = 32'h000FF000;
        1: verticalPosition = 32'hFF000000;
        2: verticalPosition = 32'h000000FF;
        default: verticalPosition = 32'h80000001;
      endcase
      if ($urandom_range(0, 24) == 0) doReset(1);
      run($urandom_range(1, 30));
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
